spi_master: RTL

- Byte-oriented SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, active-low SSEL.
- It is the other end of the FPGA's SPI slave receiver. It drives SCK/MOSI/SSEL toward an SPI target (on-board flash, DAC, or an FPGA-side slave in loopback test) and shifts MISO in.
- Core logic moves bytes over a valid/ready TX stream and a valid-only RX pulse.
- One SSEL assertion spans a message of 1..n bytes, terminated by tx_last.

---
 rtl/spi_master_pkg.sv | 23 ++
 rtl/spi_phase_timer.sv | 25 ++
 rtl/spi_master.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared SPI initiator types: FSM state encoding and the idle levels of the SPI pins.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        NEXT  = 3'd4,
        HOLD  = 3'd5,
        GAP   = 3'd6
    } spi_state_t;

    localparam logic SCK_IDLE  = 1'b0;
    localparam logic MOSI_IDLE = 1'b1;
    localparam logic SSEL_IDLE = 1'b1;

    // Phase lengths are parameters in 1..255; narrow them to the timer width.
    function automatic logic [7:0] phase_len(input int unsigned cycles);
        return cycles[7:0];
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable 8-bit down-counter; a phase loaded with N ends after N cycles (done in the last one).
// No handshake: load always wins, the count parks at zero.
module spi_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign done = (cnt <= 8'd1);

endmodule

// File: rtl/spi_master.sv
// Mode-0 MSB-first SPI initiator; byte accepted -> rx_valid after CS_SETUP+16*CLK_DIV edges (first byte).
// tx_ready only in IDLE/NEXT; rx_valid is a single unthrottled pulse.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 1,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_last,
    input  logic        abort,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        busy,
    output logic [15:0] byte_cnt,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        SSEL
);

    spi_state_t state;
    logic [6:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] bitcnt;
    logic       last_q;
    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       tmr_done;
    logic       abort_hit;

    assign tx_ready  = (state == IDLE) || (state == NEXT);
    assign busy      = (state != IDLE);
    assign abort_hit = abort && (state != IDLE) && (state != GAP);

    spi_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Timer reload mirrors the state transitions below: each new phase is loaded on its entry edge.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = 8'd0;
        case (state)
            IDLE: if (tx_valid) begin
                tmr_load = 1'b1;
                tmr_val  = phase_len(CS_SETUP);
            end
            SETUP, LOW: if (tmr_done) begin
                tmr_load = 1'b1;
                tmr_val  = phase_len(CLK_DIV);
            end
            HIGH: if (tmr_done) begin
                tmr_load = (bitcnt != 3'd7) || last_q;
                tmr_val  = (bitcnt != 3'd7) ? phase_len(CLK_DIV) : phase_len(CS_HOLD);
            end
            NEXT: if (tx_valid) begin
                tmr_load = 1'b1;
                tmr_val  = phase_len(CLK_DIV);
            end
            HOLD: if (tmr_done) begin
                tmr_load = 1'b1;
                tmr_val  = phase_len(CS_GAP);
            end
            default: ;
        endcase
        if (abort_hit) begin
            tmr_load = 1'b1;
            tmr_val  = phase_len(CS_GAP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            SSEL     <= SSEL_IDLE;
            SCK      <= SCK_IDLE;
            MOSI     <= MOSI_IDLE;
            rx_valid <= 1'b0;
            rx_data  <= 8'd0;
            byte_cnt <= 16'd0;
            tx_sr    <= 7'd0;
            rx_sr    <= 8'd0;
            bitcnt   <= 3'd0;
            last_q   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (abort_hit) begin
                // Partial byte is dropped; the gap still guarantees SSEL high time.
                state <= GAP;
                SSEL  <= SSEL_IDLE;
                SCK   <= SCK_IDLE;
                MOSI  <= MOSI_IDLE;
            end else begin
                case (state)
                    IDLE: if (tx_valid) begin
                        tx_sr  <= tx_data[6:0];
                        MOSI   <= tx_data[7];
                        last_q <= tx_last;
                        bitcnt <= 3'd0;
                        SSEL   <= 1'b0;
                        state  <= SETUP;
                    end
                    SETUP: if (tmr_done) state <= LOW;
                    LOW: if (tmr_done) begin
                        SCK   <= 1'b1;
                        rx_sr <= {rx_sr[6:0], MISO};
                        state <= HIGH;
                    end
                    HIGH: if (tmr_done) begin
                        SCK <= 1'b0;
                        if (bitcnt != 3'd7) begin
                            bitcnt <= bitcnt + 3'd1;
                            MOSI   <= tx_sr[6];
                            tx_sr  <= {tx_sr[5:0], 1'b0};
                            state  <= LOW;
                        end else begin
                            rx_valid <= 1'b1;
                            rx_data  <= rx_sr;
                            byte_cnt <= byte_cnt + 16'd1;
                            state    <= last_q ? HOLD : NEXT;
                        end
                    end
                    NEXT: if (tx_valid) begin
                        tx_sr  <= tx_data[6:0];
                        MOSI   <= tx_data[7];
                        last_q <= tx_last;
                        bitcnt <= 3'd0;
                        state  <= LOW;
                    end
                    HOLD: if (tmr_done) begin
                        SSEL  <= SSEL_IDLE;
                        MOSI  <= MOSI_IDLE;
                        state <= GAP;
                    end
                    GAP: if (tmr_done) begin
                        byte_cnt <= 16'd0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
